// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: state codes and widths shared by the PLL reset sequencer.
package pll_seq_pkg;
  localparam int CNT_W = 16;
  localparam int RETRY_W = 4;
  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = 8'd255;
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with async active-low clear.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, waits for stable lock with retries, releases core reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               req_ack,
  output logic               fail,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);
  localparam logic [CNT_W-1:0]   RST_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   ST_END  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  state_t st, nx;
  logic [CNT_W-1:0] cnt;
  logic [RETRY_W-1:0] retry_d, retry_inc;
  logic [LOSS_W-1:0] loss_d;
  logic locked_s, pending, pend_d, ack_d, give_up;
  sync_2ff u_sync (.clk(refclk), .rst_n(rst_n), .d(locked), .q(locked_s));
  assign state = st;
  assign retry_inc = retry_cnt + 1'b1;
  assign give_up = retry_inc >= RETRY_LIM;
  always_comb begin
    nx = st;
    retry_d = retry_cnt;
    loss_d = loss_cnt;
    pend_d = pending | req;
    ack_d = 1'b0;
    case (st)
      HOLD: nx = (cnt == RST_END) ? WAIT_LOCK : HOLD;
      WAIT_LOCK:
        if (locked_s) nx = STABLE;
        else if (cnt == TO_END) begin
          retry_d = retry_inc;
          nx = give_up ? FAIL : HOLD;
        end
      STABLE:
        if (!locked_s) begin
          retry_d = retry_inc;
          nx = give_up ? FAIL : HOLD;
        end else if (cnt == ST_END) nx = RUN;
      RUN: begin
        nx = (!locked_s || req) ? HOLD : RUN;
        loss_d = (!locked_s && loss_cnt != LOSS_MAX) ? loss_cnt + 1'b1 : loss_cnt;
      end
      FAIL:
        if (req) begin
          nx = HOLD;
          retry_d = '0;
        end
      default: nx = HOLD;
    endcase
    // RUN entry completes any outstanding request
    if (nx == RUN && st != RUN) begin
      retry_d = '0;
      ack_d = pend_d;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      st <= HOLD;
      cnt <= '0;
      retry_cnt <= '0;
      loss_cnt <= '0;
      pending <= 1'b0;
      pll_rst <= 1'b1;
      sys_rst_n <= 1'b0;
      req_ack <= 1'b0;
      fail <= 1'b0;
    end else begin
      st <= nx;
      cnt <= (nx != st) ? '0 : cnt + 1'b1;
      retry_cnt <= retry_d;
      loss_cnt <= loss_d;
      pending <= pend_d;
      pll_rst <= (nx == HOLD) || (nx == FAIL);
      sys_rst_n <= nx == RUN;
      req_ack <= ack_d;
      fail <= nx == FAIL;
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the system PLL (50 MHz reference in; 56/14 MHz out) from power-up through lock, and releases the core reset only once lock is proven stable.
- Pulses the PLL reset and bounds the wait for lock, retrying up to a limit before flagging failure.
- Re-sequences on lock loss or on a soft request from the on-screen menu.
- Runs entirely in the reference-clock domain; consumers synchronise `sys_rst_n` into their own domains.

Parameters:
- `RST_CYCLES`, 16: PLL reset pulse length, in refclk cycles (1..65535).
- `LOCK_TIMEOUT`, 65535: maximum refclk cycles spent waiting for lock (2..65535).
- `LOCK_STABLE`, 1024: consecutive cycles of synchronised lock required before release (1..65535).
- `MAX_RETRY`, 3: number of timeouts/unstable locks tolerated before FAIL (1..15).

Ports:
- `refclk`  in  1  reference clock (50 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `locked`  in  1  PLL lock; asynchronous, synchronised internally.
- `req`  in  1  soft re-sequence request; level, sampled each cycle.
- `pll_rst`  out  1  active-high reset driving the PLL.
- `sys_rst_n`  out  1  active-low core reset; 1 only in RUN.
- `req_ack`  out  1  one-cycle pulse on RUN entry that completes a pending request.
- `fail`  out  1  set in FAIL state.
- `state`  out  3  current state code.
- `retry_cnt`  out  4  retries since last RUN entry.
- `loss_cnt`  out  8  lock losses seen in RUN; saturates at 255.

Behaviour:
- **Reset (`rst_n`=0, asynchronous):** `state`=HOLD, counter=0, `pll_rst`=1, `sys_rst_n`=0, `req_ack`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, pending=0, sync flops=0.
- **Synchronisation:** `locked` passes through 2 flops, giving `locked_s` 2 cycles after the `locked` edge. Only `locked_s` is used.
- **Registered outputs:** all outputs are registered and decoded from the next state, so each reflects the current state with zero additional latency.
- **State codes:** HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Other codes go to HOLD.
- **16-bit counter:** cleared on every state change.
- **HOLD:** `pll_rst`=1. When cnt==`RST_CYCLES`-1, go to WAIT_LOCK. `pll_rst` is therefore high exactly `RST_CYCLES` cycles per entry.
- **WAIT_LOCK:** `pll_rst`=0.
  - `locked_s`=1: go to STABLE.
  - Otherwise, at cnt==`LOCK_TIMEOUT`-1: increment `retry_cnt`, then go to FAIL if the new value ≥`MAX_RETRY`, else to HOLD.
- **STABLE:** `pll_rst`=0.
  - `locked_s`=0: retry as for a timeout.
  - cnt==`LOCK_STABLE`-1 with `locked_s`=1: go to RUN.
- **RUN:** `sys_rst_n`=1.
  - On entry: `retry_cnt` clears. If pending=1, pulse `req_ack` and clear pending.
  - `locked_s`=0: go to HOLD and increment `loss_cnt` (saturating).
  - `req`=1: go to HOLD and set pending.
  - Both in the same cycle: HOLD, `loss_cnt` incremented, pending set.
- **FAIL:** `pll_rst`=1, `fail`=1, `sys_rst_n`=0. Exits only on `req`=1, which goes to HOLD, clears `retry_cnt`, and sets pending. `locked` is ignored.
- **Requests outside RUN/FAIL:** `req`=1 sets pending only; the sequence is not restarted. If `req` is still high on RUN entry, RUN sees it, acks, and immediately re-sequences. The requester must drop `req` on `req_ack`.
- **`loss_cnt`:** cleared only by `rst_n`.
- **`rst_n` asserted mid-sequence:** immediate return to the reset values; no partial pulses are preserved.

Decomposition:
- **Package `pll_seq_pkg`:**
  - state enum and codes;
  - `CNT_W`=16, `RETRY_W`=4, `LOSS_W`=8;
  - `LOSS_MAX`=255.
- **Sub-module `sync_2ff`:** 1-bit two-flop synchroniser with async active-low clear; reusable elsewhere in the core.
- **FSM and counters:** stay in this module.

Test Plan (`RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `MAX_RETRY`=2):
- **Clean bring-up:** release `rst_n`; the PLL model raises `locked` 3 cycles after `pll_rst` falls → `pll_rst` high 4 cycles; `state` goes 1→2 two cycles after `locked`; `sys_rst_n` rises 8 cycles after STABLE entry; `retry_cnt`=0.
- **Timeout then success:** no lock on the first attempt, lock on the second → `pll_rst` re-pulses 4 cycles after 20 cycles in WAIT_LOCK; `retry_cnt`=1, then back to 0 on RUN entry.
- **Fail:** `locked` held 0 → two timeouts, then `state`=4, `fail`=1, `pll_rst`=1 steady. Pulse `req` → HOLD, `fail`=0; with lock present, RUN is reached and `req_ack` pulses once.
- **Lock glitch in STABLE:** `locked` low 3 cycles at STABLE cnt 5 → HOLD, `retry_cnt`=1, `sys_rst_n` stays 0 throughout.
- **Loss plus request in RUN, same cycle:** drop `locked` and raise `req` → `sys_rst_n`=0 next cycle, `loss_cnt`=1; after re-lock, one `req_ack` on RUN entry. Force 300 losses → `loss_cnt` saturates at 255.
- **Async reset mid-STABLE:** assert `rst_n` at STABLE cnt 4 → outputs take their reset values with no clock edge; after release the full sequence restarts from HOLD.
